// File: rtl/jk_pkg.sv
// Shared JK opcode constants and sequencer state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package jk_pkg;

    // Per-bit excitation command, packed as {j,k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRIVE = 2'd2,
        CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Target handshake plus JK bank drive/readback and status bundle.
// Latency: none (wiring only).
// Backpressure: tgt_valid/tgt_ready; slave side is the sequencer.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ff_reset;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] mismatch;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j, k, ff_reset, busy, done, err, mismatch
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j, k, ff_reset, busy, done, err, mismatch
    );
endinterface

// File: rtl/jk_excite_bit.sv
// Maps one bit's current/next value to its JK command; JK_PREFER_TOGGLE_EN uses TOGGLE for changes.
// Latency: combinational.
// Backpressure: none.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic cur,
    input  logic nxt,
    output logic j,
    output logic k
);
    logic [1:0] op;

    always_comb begin
        op = JK_HOLD;
`ifdef JK_PREFER_TOGGLE_EN
        if (cur != nxt) begin
            op = JK_TOGGLE;
        end
`else
        if (!cur && nxt) begin
            op = JK_SET;
        end else if (cur && !nxt) begin
            op = JK_RESET;
        end
`endif
    end

    assign {j, k} = op;
endmodule

// File: rtl/jk_bank_sequencer.sv
// Drives an external JK bank to a requested value, verifies via readback, retries, resyncs on failure.
// Latency: done 2 cycles after accept, +2 per retry; JK_PREFER_TOGGLE_EN selects TOGGLE excitation.
// Backpressure: tgt_ready only in IDLE; offers made while busy are not taken.
module jk_bank_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               reset,
    jk_bank_sequencer_if.slave bus
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] mismatch_q;
    logic [RW-1:0]    retry_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic             check_ok;
    logic             retry_left;

    assign check_ok   = (bus.q_fb == target_q);
    assign retry_left = (retry_q < RETRY_LIMIT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite_bit u_excite (
            .cur (shadow_q[i]),
            .nxt (target_q[i]),
            .j   (exc_j[i]),
            .k   (exc_k[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    if (bus.tgt_valid) state_d = DRIVE;
            DRIVE:   state_d = CHECK;
            CHECK: begin
                if (check_ok) begin
                    state_d = IDLE;
                end else if (retry_left) begin
                    state_d = DRIVE;
                end else begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            shadow_q   <= '0;
            target_q   <= '0;
            retry_q    <= '0;
            mismatch_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // Pulses are registered so nothing combinational reaches outputs from q_fb
            done_q  <= (state_q == CHECK) && check_ok;
            err_q   <= (state_q == CHECK) && !check_ok && !retry_left;
            case (state_q)
                INIT:  shadow_q <= '0;
                IDLE: begin
                    if (bus.tgt_valid) begin
                        target_q   <= bus.tgt_data;
                        retry_q    <= '0;
                        mismatch_q <= '0;
                    end
                end
                DRIVE: shadow_q <= target_q;
                CHECK: begin
                    if (!check_ok) begin
                        if (retry_left) begin
                            shadow_q <= bus.q_fb;
                            retry_q  <= retry_q + RW'(1);
                        end else begin
                            mismatch_q <= bus.q_fb ^ target_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tgt_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ff_reset  = (state_q == INIT);
    assign bus.j         = (state_q == DRIVE) ? exc_j : '0;
    assign bus.k         = (state_q == DRIVE) ? exc_k : '0;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mismatch  = mismatch_q;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: JK bank with injectable faults, transaction-level expectation planner,
// per-cycle output comparison, plus directed literal checks and a randomized phase.
module tb_jk_bank_sequencer;
    localparam int W  = 4;
    localparam int MR = 2;

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic       ffr;
        logic       done;
        logic       err;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] mm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    // bank fault knobs: stuck bits read back 0; ign_mask bits ignore the next non-HOLD drive once armed
    bit [3:0] stuck = '0;
    bit [3:0] ign_mask = '0;
    int       ign_arm = 0;
    int       ign_seen = 0;
    bit [3:0] bank = '0;
    int       drives = 0;

    exp_t     expq[$];
    bit       started = 1'b0;
    bit [3:0] m_shadow = '0;
    bit [3:0] m_bank = '0;
    bit [3:0] m_mm = '0;

    jk_bank_sequencer_if #(.WIDTH(W)) bus ();

    jk_bank_sequencer #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.q_fb = bank & ~stuck;

    function automatic bit [3:0] bank_next(bit [3:0] cur, bit [3:0] jv, bit [3:0] kv, bit [3:0] ign);
        bit [3:0] r = cur;
        for (int i = 0; i < 4; i++) begin
            if (!ign[i]) begin
                case ({jv[i], kv[i]})
                    2'b01:   r[i] = 1'b0;
                    2'b10:   r[i] = 1'b1;
                    2'b11:   r[i] = ~cur[i];
                    default: r[i] = cur[i];
                endcase
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.ff_reset === 1'b1) begin
            bank <= '0;
        end else begin
            bank <= bank_next(bank, bus.j, bus.k, (ign_arm != ign_seen) ? ign_mask : 4'b0);
            if ((bus.j | bus.k) != 4'b0) begin
                ign_seen <= ign_arm;
                drives   <= drives + 1;
            end
        end
    end

    function automatic exp_t mk(bit r, bit by, bit f, bit d, bit e, bit [3:0] jj, bit [3:0] kk, bit [3:0] m);
        exp_t x;
        x.rdy = r; x.busy = by; x.ffr = f; x.done = d; x.err = e;
        x.j = jj; x.k = kk; x.mm = m;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Plans the whole transaction from the rules: each attempt is a DRIVE then a CHECK record,
    // ending in a done-IDLE record or an err-INIT record.
    task automatic plan(input bit [3:0] t);
        bit [3:0] cs, jj, kk, fb;
        bit       ign_on;
        ign_on = (ign_arm != ign_seen);
        m_mm = '0;
        cs = m_shadow;
        fb = '0;
        for (int a = 0; a <= MR; a++) begin
`ifdef JK_PREFER_TOGGLE_EN
            jj = cs ^ t;
            kk = cs ^ t;
`else
            jj = ~cs & t;
            kk = cs & ~t;
`endif
            expq.push_back(mk(0, 1, 0, 0, 0, jj, kk, m_mm));
            m_bank = bank_next(m_bank, jj, kk, ign_on ? ign_mask : 4'b0);
            if ((jj | kk) != 4'b0) ign_on = 1'b0;
            fb = m_bank & ~stuck;
            expq.push_back(mk(0, 1, 0, 0, 0, 4'b0, 4'b0, m_mm));
            if (fb == t) begin
                expq.push_back(mk(1, 0, 0, 1, 0, 4'b0, 4'b0, m_mm));
                m_shadow = t;
                return;
            end
            cs = fb;
        end
        m_mm = fb ^ t;
        expq.push_back(mk(0, 1, 1, 0, 1, 4'b0, 4'b0, m_mm));
        m_shadow = '0;
        m_bank = '0;
    endtask

    task automatic monitor();
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            e = mk(1, 0, 0, 0, 0, 4'b0, 4'b0, m_mm);
            if (started) begin
                if (expq.size() > 0) e = expq.pop_front();
                g = {bus.tgt_ready, bus.busy, bus.ff_reset, bus.done, bus.err, bus.j, bus.k, bus.mismatch};
                chk("cycle rdy/busy/ffr/done/err/j/k/mm", 32'(g), 32'(e));
            end
            if (reset) begin
                expq.delete();
                m_mm = '0;
                m_shadow = '0;
                m_bank = '0;
                expq.push_back(mk(0, 1, 1, 0, 0, 4'b0, 4'b0, 4'b0));
                started = 1'b1;
            end else if (started && e.rdy && bus.tgt_valid) begin
                plan(bus.tgt_data);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers t while idle; returns #1 after the accepting edge (DRIVE cycle).
    task automatic send(input logic [3:0] t);
        int n = 0;
        while (bus.tgt_ready !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send timeout: tgt_ready=%b required 1", bus.tgt_ready);
        end
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = t;
        step(1);
        bus.tgt_valid = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;
        fork
            monitor();
        join_none

        // reset state
        step(3);
        reset = 1'b0;
        chk("init ff_reset", 32'(bus.ff_reset), 32'd1);
        chk("init tgt_ready", 32'(bus.tgt_ready), 32'd0);
        chk("init busy", 32'(bus.busy), 32'd1);
        step(1);
        chk("idle tgt_ready", 32'(bus.tgt_ready), 32'd1);
        chk("idle ff_reset", 32'(bus.ff_reset), 32'd0);

        // 0000 -> 1010
        send(4'b1010);
        chk("drive1 j", 32'(bus.j), 32'b1010);
`ifdef JK_PREFER_TOGGLE_EN
        chk("drive1 k", 32'(bus.k), 32'b1010);
`else
        chk("drive1 k", 32'(bus.k), 32'b0000);
`endif
        step(2);
        chk("t1 done", 32'(bus.done), 32'd1);
        chk("t1 err", 32'(bus.err), 32'd0);
        chk("t1 bank", 32'(bus.q_fb), 32'b1010);

        // 1010 -> 0110
        send(4'b0110);
`ifdef JK_PREFER_TOGGLE_EN
        chk("drive2 j", 32'(bus.j), 32'b1100);
        chk("drive2 k", 32'(bus.k), 32'b1100);
`else
        chk("drive2 j", 32'(bus.j), 32'b0100);
        chk("drive2 k", 32'(bus.k), 32'b1000);
`endif
        step(2);
        chk("t2 done", 32'(bus.done), 32'd1);

        // bit0 stuck at 0: three drives then error and resync
        stuck = 4'b0001;
        d0 = drives;
        send(4'b0001);
        step(6);
        chk("stuck err", 32'(bus.err), 32'd1);
        chk("stuck done", 32'(bus.done), 32'd0);
        chk("stuck ff_reset", 32'(bus.ff_reset), 32'd1);
        chk("stuck mismatch", 32'(bus.mismatch), 32'b0001);
        step(1);
        chk("stuck drives", 32'(drives - d0), 32'd3);
        chk("post-err ready", 32'(bus.tgt_ready), 32'd1);
        stuck = 4'b0000;

        // bit2 ignored on first drive only: one retry then success
        ign_mask = 4'b0100;
        ign_arm++;
        send(4'b0100);
        chk("ign drive1 j", 32'(bus.j), 32'b0100);
        step(2);
        chk("ign retry j", 32'(bus.j), 32'b0100);
`ifdef JK_PREFER_TOGGLE_EN
        chk("ign retry k", 32'(bus.k), 32'b0100);
`else
        chk("ign retry k", 32'(bus.k), 32'b0000);
`endif
        step(2);
        chk("ign done", 32'(bus.done), 32'd1);
        chk("ign err", 32'(bus.err), 32'd0);

        // reset during CHECK discards the target
        send(4'b1011);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst ff_reset", 32'(bus.ff_reset), 32'd1);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        step(1);
        chk("rst ready", 32'(bus.tgt_ready), 32'd1);
        send(4'b0000);
        chk("rst shadow j", 32'(bus.j), 32'b0000);
        chk("rst shadow k", 32'(bus.k), 32'b0000);
        step(2);
        chk("rst hold done", 32'(bus.done), 32'd1);

        // valid held high with 1111: back-to-back accepts, none while busy
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 4'b1111;
        step(1);
        chk("held drive j", 32'(bus.j), 32'b1111);
        step(1);
        chk("held busy ready", 32'(bus.tgt_ready), 32'd0);
        step(1);
        chk("held done1", 32'(bus.done), 32'd1);
        step(1);
        chk("held redrive j", 32'(bus.j), 32'b0000);
        chk("held redrive k", 32'(bus.k), 32'b0000);
        chk("held redrive busy", 32'(bus.busy), 32'd1);
        step(2);
        chk("held done2", 32'(bus.done), 32'd1);
        bus.tgt_valid = 1'b0;

        // randomized traffic, faults and resets
        for (int n = 0; n < 3000; n++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
            if (!reset && bus.tgt_ready === 1'b1 && $urandom_range(0, 7) == 0) begin
                stuck = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
                if ($urandom_range(0, 2) == 0) begin
                    ign_mask = 4'($urandom_range(1, 15));
                    ign_arm++;
                end
            end
            bus.tgt_valid = ($urandom_range(0, 3) != 0);
            bus.tgt_data  = 4'($urandom_range(0, 15));
            step(1);
        end
        bus.tgt_valid = 1'b0;
        reset = 1'b0;
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
